// File: rtl/ra_bist_seq.sv
// ra_bist_seq: command decoder and march/checkerboard sequencer for the array BIST mux.
// Build option: define RA_BIST_SEQ_RD1_EN to mirror every test read onto port 1 and
// compare port-1 data as well (a miss on either port counts as one fail).
// Handshake: ctl is qualified only by ctl_val and has no backpressure. Every cycle with
// ctl_val=1 is consumed as one command or data beat. Read data from the array is valid
// exactly RD_LAT cycles after the cycle in which bist_rd*_enb is high.
module ra_bist_seq #(
   parameter int RD_LAT = 1,
   parameter int FCNT_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ctl,
   input  logic        ctl_val,
   input  logic [71:0] rd0_dat,
   input  logic [71:0] rd1_dat,
   output logic        active,
   output logic [31:0] status,
   output logic [71:0] rd_dat,
   output logic        bist_rd0_enb,
   output logic [5:0]  bist_rd0_adr,
   output logic        bist_rd1_enb,
   output logic [5:0]  bist_rd1_adr,
   output logic        bist_wr0_enb,
   output logic [5:0]  bist_wr0_adr,
   output logic [71:0] bist_wr0_dat,
   output logic [2:0]  dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_WAIT, S_WD0, S_WD1, S_WD2, S_WR, S_RUN, S_DRAIN
   } state_t;

   localparam logic [71:0] CB = {36{2'b01}};

   state_t            state_q, state_d;
   logic [1:0]        elem_q, elem_d;
   logic [5:0]        a_q, a_d;
   logic              ph_q, ph_d;
   logic              tst_q, tst_d;
   logic [1:0]        drn_q, drn_d;
   logic [5:0]        wadr_q, wadr_d;
   logic [47:0]       wdat_q, wdat_d;
   logic              active_q;
   logic              rd_enb_q, rd_enb_d, rd_man_q, rd_man_d;
   logic [5:0]        rd_adr_q, rd_adr_d;
   logic [71:0]       exp_q, exp_d;
   logic              wr_enb_q, wr_enb_d;
   logic [5:0]        wr_adr_q, wr_adr_d;
   logic [71:0]       wr_dat_q, wr_dat_d;
   logic              done_q, done_d, fail_q, fail_d, bad_q, bad_d;
   logic [5:0]        ffadr_q, ffadr_d, lradr_q, lradr_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [71:0]       rdd_q, rdd_d;
   // Read pipe: valid, manual-read flag, address and expected data travel with each read.
   logic [RD_LAT-1:0] pv_q, pm_q;
   logic [5:0]        pa_q [RD_LAT];
   logic [71:0]       pe_q [RD_LAT];
   logic              flush, mis, two, down, is_rd, iss_go, iss_p;
   logic [1:0]        iss_e;
   logic [5:0]        iss_a;
   logic [71:0]       pat;
   logic              unused_ctl;

   assign unused_ctl = ^ctl[27:24];

`ifdef RA_BIST_SEQ_RD1_EN
   assign mis          = (rd0_dat != pe_q[RD_LAT-1]) || (rd1_dat != pe_q[RD_LAT-1]);
   assign bist_rd1_enb = rd_enb_q;
   assign bist_rd1_adr = rd_adr_q;
`else
   logic unused_rd1;
   assign unused_rd1   = ^rd1_dat;
   assign mis          = (rd0_dat != pe_q[RD_LAT-1]);
   assign bist_rd1_enb = 1'b0;
   assign bist_rd1_adr = 6'd0;
`endif

   assign active       = active_q;
   assign rd_dat       = rdd_q;
   assign bist_rd0_enb = rd_enb_q;
   assign bist_rd0_adr = rd_adr_q;
   assign bist_wr0_enb = wr_enb_q;
   assign bist_wr0_adr = wr_adr_q;
   assign bist_wr0_dat = wr_dat_q;
   assign dbg_state_o  = state_q;

   // Status word assembled from registered fields.
   always_comb begin
      status                = '0;
      status[31]            = active_q;
      status[30]            = done_q;
      status[29]            = fail_q;
      status[28]            = bad_q;
      status[27:22]         = ffadr_q;
      status[21:16]         = lradr_q;
      status[FCNT_W-1:0]    = fcnt_q;
   end

   // Next state, next array operation, and result bookkeeping.
   always_comb begin
      state_d = state_q;  elem_d = elem_q;  a_d = a_q;  ph_d = ph_q;  tst_d = tst_q;
      drn_d = drn_q;  wadr_d = wadr_q;  wdat_d = wdat_q;
      rd_enb_d = 1'b0;  rd_adr_d = '0;  rd_man_d = 1'b0;  exp_d = '0;
      wr_enb_d = 1'b0;  wr_adr_d = '0;  wr_dat_d = '0;
      done_d = done_q;  fail_d = fail_q;  bad_d = bad_q;  ffadr_d = ffadr_q;
      lradr_d = lradr_q;  fcnt_d = fcnt_q;  rdd_d = rdd_q;
      flush = 1'b0;  iss_go = 1'b0;  iss_e = elem_q;  iss_a = a_q;  iss_p = 1'b0;
      pat = '0;  is_rd = 1'b0;
      // March elements e1/e2 take two cycles per address; e2 walks downwards.
      two  = !tst_q && (elem_q == 2'd1 || elem_q == 2'd2);
      down = !tst_q && (elem_q == 2'd2);

      if (state_q != S_IDLE && ctl_val && ctl == 32'h0) begin
         // Abort: drop everything in flight, done stays clear.
         state_d = S_IDLE;
         flush   = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: if (ctl_val) begin
               done_d = 1'b0;  fail_d = 1'b0;  bad_d = 1'b0;  ffadr_d = '0;  fcnt_d = '0;
               case (ctl[31:28])
                  4'h0: ;
                  4'h8: begin
                     rd_enb_d = 1'b1;  rd_adr_d = ctl[5:0];  rd_man_d = 1'b1;
                     state_d  = S_RD_WAIT;
                  end
                  4'h9: begin
                     wadr_d  = ctl[5:0];
                     state_d = S_WD0;
                  end
                  4'hF: begin
                     if (ctl[7:0] <= 8'd1) begin
                        tst_d   = ctl[0];
                        iss_go  = 1'b1;  iss_e = 2'd0;  iss_a = 6'd0;  iss_p = 1'b0;
                        state_d = S_RUN;
                     end else begin
                        bad_d = 1'b1;
                     end
                  end
                  default: bad_d = 1'b1;
               endcase
            end
            S_RD_WAIT: if (pv_q[RD_LAT-1] && pm_q[RD_LAT-1]) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            S_WD0: if (ctl_val) begin
               wdat_d[47:24] = ctl[23:0];
               state_d       = S_WD1;
            end
            S_WD1: if (ctl_val) begin
               wdat_d[23:0] = ctl[23:0];
               state_d      = S_WD2;
            end
            S_WD2: if (ctl_val) begin
               wr_enb_d = 1'b1;  wr_adr_d = wadr_q;  wr_dat_d = {wdat_q, ctl[23:0]};
               state_d  = S_WR;
            end
            S_WR: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            S_RUN: begin
               iss_go = 1'b1;
               if (two && !ph_q) begin
                  iss_p = 1'b1;
               end else if (a_q == (down ? 6'd0 : 6'd63)) begin
                  if (elem_q == 2'd3) begin
                     iss_go  = 1'b0;
                     drn_d   = 2'(RD_LAT - 1);
                     state_d = S_DRAIN;
                  end else begin
                     iss_e = elem_q + 2'd1;
                     iss_a = (!tst_q && elem_q == 2'd1) ? 6'd63 : 6'd0;
                  end
               end else begin
                  iss_a = down ? a_q - 6'd1 : a_q + 6'd1;
               end
            end
            S_DRAIN: begin
               if (drn_q == 2'd0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  drn_d = drn_q - 2'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
         if (ctl_val && (state_q inside {S_RD_WAIT, S_WR, S_RUN, S_DRAIN}))
            bad_d = 1'b1;
      end

      // Translate the element/address/phase being issued into a read or a write.
      if (iss_go) begin
         elem_d = iss_e;  a_d = iss_a;  ph_d = iss_p;
         if (!tst_d) begin
            pat   = ((iss_e == 2'd1 && iss_p) || (iss_e == 2'd2 && !iss_p)) ? {72{1'b1}} : 72'h0;
            is_rd = (iss_e == 2'd3) || ((iss_e == 2'd1 || iss_e == 2'd2) && !iss_p);
         end else begin
            pat   = iss_a[0] ? ~CB : CB;
            if (iss_e[1]) pat = ~pat;
            is_rd = iss_e[0];
         end
         if (is_rd) begin
            rd_enb_d = 1'b1;  rd_adr_d = iss_a;  exp_d = pat;
         end else begin
            wr_enb_d = 1'b1;  wr_adr_d = iss_a;  wr_dat_d = pat;
         end
      end

      // Retire the read at the end of the pipe: capture a manual read or score a test read.
      if (!flush && pv_q[RD_LAT-1]) begin
         if (pm_q[RD_LAT-1]) begin
            rdd_d   = rd0_dat;
            lradr_d = pa_q[RD_LAT-1];
         end else if (mis) begin
            fail_d = 1'b1;
            if (!fail_q) ffadr_d = pa_q[RD_LAT-1];
            if (fcnt_q != {FCNT_W{1'b1}}) fcnt_d = fcnt_q + FCNT_W'(1);
         end
      end
   end

   // Control, output and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;  elem_q <= '0;  a_q <= '0;  ph_q <= 1'b0;  tst_q <= 1'b0;
         drn_q <= '0;  wadr_q <= '0;  wdat_q <= '0;  active_q <= 1'b0;
         rd_enb_q <= 1'b0;  rd_adr_q <= '0;  rd_man_q <= 1'b0;  exp_q <= '0;
         wr_enb_q <= 1'b0;  wr_adr_q <= '0;  wr_dat_q <= '0;
         done_q <= 1'b0;  fail_q <= 1'b0;  bad_q <= 1'b0;  ffadr_q <= '0;
         lradr_q <= '0;  fcnt_q <= '0;  rdd_q <= '0;
      end else begin
         state_q <= state_d;  elem_q <= elem_d;  a_q <= a_d;  ph_q <= ph_d;  tst_q <= tst_d;
         drn_q <= drn_d;  wadr_q <= wadr_d;  wdat_q <= wdat_d;  active_q <= (state_d != S_IDLE);
         rd_enb_q <= rd_enb_d;  rd_adr_q <= rd_adr_d;  rd_man_q <= rd_man_d;  exp_q <= exp_d;
         wr_enb_q <= wr_enb_d;  wr_adr_q <= wr_adr_d;  wr_dat_q <= wr_dat_d;
         done_q <= done_d;  fail_q <= fail_d;  bad_q <= bad_d;  ffadr_q <= ffadr_d;
         lradr_q <= lradr_d;  fcnt_q <= fcnt_d;  rdd_q <= rdd_d;
      end
   end

   // Read pipe: shifts RD_LAT stages so the compare lines up with the returned data.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         pv_q <= '0;
         pm_q <= '0;
      end else begin
         pv_q[0] <= rd_enb_q;
         pm_q[0] <= rd_man_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pm_q[i] <= pm_q[i-1];
         end
      end
      pa_q[0] <= rd_adr_q;
      pe_q[0] <= exp_q;
      for (int i = 1; i < RD_LAT; i++) begin
         pa_q[i] <= pa_q[i-1];
         pe_q[i] <= pe_q[i-1];
      end
   end

endmodule
